// File: rtl/tmon_poll_ctrl_pkg.sv
// Shared definitions for the temperature-monitor polling scheduler.
package tmon_poll_ctrl_pkg;

   typedef logic bool_t;

   // Operations understood by tmon_master.
   typedef enum logic {
      NOOP      = 1'b0,
      READ_TEMP = 1'b1
   } TMON_OP;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      BUSY   = 2'd2,
      UPDATE = 2'd3
   } tmon_poll_state_t;

   localparam int HYST_DEF    = 2;
   localparam int TIMEOUT_DEF = 16;

   // A zero poll interval would never expire, so it runs as one clock.
   function automatic logic [7:0] period_eff(input logic [7:0] p);
      return (p == 8'd0) ? 8'd1 : p;
   endfunction

   function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? (a - b) : 8'd0;
   endfunction

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/tmon_poll_ctrl_if.sv
// Request/response handshake between the poll scheduler and tmon_master.
// The scheduler side is "master" (drives the request), tmon_master is "slave".
interface tmon_poll_ctrl_if;
   import tmon_poll_ctrl_pkg::*;

   TMON_OP     request;
   logic [7:0] reqData;
   logic       Done;
   logic [7:0] rspData;

   modport master (output request, output reqData, input Done, input rspData);
   modport slave  (input request, input reqData, output Done, output rspData);

endinterface

// File: rtl/tmon_alarm.sv
// Running min/max of captured temperatures and hysteretic over/under alarms.
module tmon_alarm
   import tmon_poll_ctrl_pkg::*;
#(
   parameter int HYST = HYST_DEF
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       load,
   input  logic [7:0] data,
   input  logic [7:0] hi_thresh,
   input  logic [7:0] lo_thresh,
   output logic [7:0] temp_max,
   output logic [7:0] temp_min,
   output bool_t      alarm_hi,
   output bool_t      alarm_lo
);

   localparam logic [7:0] HBAND = 8'(HYST);

   // Release levels; saturate so a threshold near 0/255 never wraps.
   logic [7:0] hi_clr_lvl;
   logic [7:0] lo_clr_lvl;

   assign hi_clr_lvl = sat_sub8(hi_thresh, HBAND);
   assign lo_clr_lvl = sat_add8(lo_thresh, HBAND);

   // Extrema start inverted so the first sample sets both.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         temp_max <= 8'h00;
         temp_min <= 8'hFF;
      end else if (load) begin
         if (data > temp_max) temp_max <= data;
         if (data < temp_min) temp_min <= data;
      end
   end

   // Set above/below threshold, release only once past the hysteresis band.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         alarm_hi <= 1'b0;
         alarm_lo <= 1'b0;
      end else if (load) begin
         if (data > hi_thresh)       alarm_hi <= 1'b1;
         else if (data < hi_clr_lvl) alarm_hi <= 1'b0;
         if (data < lo_thresh)       alarm_lo <= 1'b1;
         else if (data > lo_clr_lvl) alarm_lo <= 1'b0;
      end
   end

endmodule

// File: rtl/tmon_poll_ctrl.sv
// Periodic READ_TEMP scheduler for tmon_master: interval timer, per-request
// timeout, sample capture, and hand-off to the min/max/alarm tracker.
module tmon_poll_ctrl
   import tmon_poll_ctrl_pkg::*;
#(
   parameter int HYST    = HYST_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              enable,
   input  logic [7:0]        period,
   input  logic [7:0]        hi_thresh,
   input  logic [7:0]        lo_thresh,
   input  logic              clr_err,
   tmon_poll_ctrl_if.master  bus,
   output logic [7:0]        sample,
   output logic              sample_valid,
   output logic [7:0]        temp_max,
   output logic [7:0]        temp_min,
   output bool_t             alarm_hi,
   output bool_t             alarm_lo,
   output bool_t             timeout_err
);

   localparam int            TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   tmon_poll_state_t state, state_nxt;
   logic [7:0]       ivl_cnt, ivl_nxt;
   logic [TW-1:0]    tmo_cnt, tmo_nxt;
   logic             capture;
   logic             tmo_hit;

   // Next state, counters and handshake outputs; request is decoded from
   // state so reset drops it to NOOP without waiting for an edge.
   always_comb begin
      state_nxt    = state;
      ivl_nxt      = ivl_cnt;
      tmo_nxt      = tmo_cnt;
      capture      = 1'b0;
      tmo_hit      = 1'b0;
      bus.request  = NOOP;
      bus.reqData  = 8'h00;
      sample_valid = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = WAIT;
               ivl_nxt   = period_eff(period);
            end
         end
         WAIT: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (ivl_cnt <= 8'd1) begin
               state_nxt = BUSY;
               tmo_nxt   = '0;
            end else begin
               ivl_nxt = ivl_cnt - 8'd1;
            end
         end
         BUSY: begin
            bus.request = READ_TEMP;
            if (bus.Done) begin
               capture   = 1'b1;
               state_nxt = UPDATE;
            end else if (tmo_cnt == TLAST) begin
               tmo_hit   = 1'b1;
               state_nxt = enable ? WAIT : IDLE;
               ivl_nxt   = period_eff(period);
            end else begin
               tmo_nxt = tmo_cnt + 1'b1;
            end
         end
         UPDATE: begin
            sample_valid = 1'b1;
            state_nxt    = enable ? WAIT : IDLE;
            ivl_nxt      = period_eff(period);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state and its counters.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         ivl_cnt <= 8'd0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         ivl_cnt <= ivl_nxt;
         tmo_cnt <= tmo_nxt;
      end
   end

   // Latch the master's result at the Done edge.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)       sample <= 8'h00;
      else if (capture) sample <= bus.rspData;
   end

   // Sticky timeout flag; a new timeout beats a simultaneous clear.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)       timeout_err <= 1'b0;
      else if (tmo_hit) timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
   end

   tmon_alarm #(.HYST(HYST)) u_alarm (
      .Clock     (Clock),
      .Reset     (Reset),
      .load      (capture),
      .data      (bus.rspData),
      .hi_thresh (hi_thresh),
      .lo_thresh (lo_thresh),
      .temp_max  (temp_max),
      .temp_min  (temp_min),
      .alarm_hi  (alarm_hi),
      .alarm_lo  (alarm_lo)
   );

endmodule

// File: tb/tb_tmon_poll_ctrl.sv
// Directed + randomized bench for tmon_poll_ctrl with an abstract reference model.
module tb_tmon_poll_ctrl;
   import tmon_poll_ctrl_pkg::*;

   localparam int HYST    = 2;
   localparam int TIMEOUT = 16;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       enable;
   logic [7:0] period;
   logic [7:0] hi_thresh;
   logic [7:0] lo_thresh;
   logic       clr_err;
   logic [7:0] sample;
   logic       sample_valid;
   logic [7:0] temp_max;
   logic [7:0] temp_min;
   bool_t      alarm_hi;
   bool_t      alarm_lo;
   bool_t      timeout_err;

   tmon_poll_ctrl_if bus();

   tmon_poll_ctrl #(.HYST(HYST), .TIMEOUT(TIMEOUT)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .enable       (enable),
      .period       (period),
      .hi_thresh    (hi_thresh),
      .lo_thresh    (lo_thresh),
      .clr_err      (clr_err),
      .bus          (bus),
      .sample       (sample),
      .sample_valid (sample_valid),
      .temp_max     (temp_max),
      .temp_min     (temp_min),
      .alarm_hi     (alarm_hi),
      .alarm_lo     (alarm_lo),
      .timeout_err  (timeout_err)
   );

   always #5 Clock = ~Clock;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model state: what the outputs should be after each capture.
   int m_sample = 0;
   int m_max    = 0;
   int m_min    = 255;
   bit m_ahi    = 1'b0;
   bit m_alo    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int eff_period(input int p);
      return (p == 0) ? 1 : p;
   endfunction

   // Apply one new temperature to the model using the thresholds in force now.
   function void model_capture(input int d);
      int hclr, lclr;
      hclr = (int'(hi_thresh) > HYST) ? int'(hi_thresh) - HYST : 0;
      lclr = (int'(lo_thresh) + HYST > 255) ? 255 : int'(lo_thresh) + HYST;
      m_sample = d;
      if (d > m_max) m_max = d;
      if (d < m_min) m_min = d;
      if (d > int'(hi_thresh)) m_ahi = 1'b1;
      else if (d < hclr)       m_ahi = 1'b0;
      if (d < int'(lo_thresh)) m_alo = 1'b1;
      else if (d > lclr)       m_alo = 1'b0;
   endfunction

   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Wait (bounded) for READ_TEMP; optionally check edges elapsed since call.
   task automatic wait_req(input int exp_gap, input bit do_gap);
      int n;
      bit found;
      bit sv_extra;
      n = 0; found = 1'b0; sv_extra = 1'b0;
      while (n < 300 && !found) begin
         tick();
         n++;
         if (bus.request == READ_TEMP) found = 1'b1;
         else if (sample_valid) sv_extra = 1'b1;
      end
      chk("req_seen", 32'(found), 32'd1);
      chk("no_stray_valid", 32'(sv_extra), 32'd0);
      if (do_gap) chk("poll_gap", 32'(n), 32'(exp_gap));
   endtask

   task automatic check_capture(input string tag);
      chk({tag, "_valid"}, 32'(sample_valid), 32'd1);
      chk({tag, "_sample"}, 32'(sample), 32'(m_sample));
      chk({tag, "_max"}, 32'(temp_max), 32'(m_max));
      chk({tag, "_min"}, 32'(temp_min), 32'(m_min));
      chk({tag, "_ahi"}, 32'(alarm_hi), 32'(m_ahi));
      chk({tag, "_alo"}, 32'(alarm_lo), 32'(m_alo));
      chk({tag, "_req_drop"}, 32'(bus.request), 32'(NOOP));
   endtask

   // Complete one poll: wait for the request, hold Done off for lat cycles,
   // then return d and check the UPDATE cycle.
   task automatic do_poll(input logic [7:0] d, input int lat, input bit do_gap);
      wait_req(eff_period(int'(period)) + 1, do_gap);
      for (int k = 0; k < lat; k++) begin
         chk("req_hold", 32'(bus.request), 32'(READ_TEMP));
         tick();
      end
      bus.Done    = 1'b1;
      bus.rspData = d;
      model_capture(int'(d));
      tick();
      bus.Done    = 1'b0;
      bus.rspData = 8'($urandom);
      check_capture("cap");
   endtask

   // Run a BUSY period with no Done; clear-test actions when with_clr is set.
   task automatic run_timeout(input bit with_clr);
      for (int k = 1; k <= TIMEOUT; k++) begin
         chk("tmo_req_hold", 32'(bus.request), 32'(READ_TEMP));
         if (with_clr) begin
            if (k == 2) chk("err_sticky", 32'(timeout_err), 32'd1);
            if (k == 3) clr_err = 1'b1;
            if (k == 4) begin
               clr_err = 1'b0;
               chk("err_cleared", 32'(timeout_err), 32'd0);
            end
            if (k == TIMEOUT) clr_err = 1'b1;
         end
         tick();
      end
      clr_err = 1'b0;
      chk("tmo_req_noop", 32'(bus.request), 32'(NOOP));
      chk("tmo_err_set", 32'(timeout_err), 32'd1);
      chk("tmo_no_valid", 32'(sample_valid), 32'd0);
   endtask

   initial begin
      int hi_exp[4];
      int lo_exp[3];
      int hi_seq[4];
      int lo_seq[3];
      int reqs;
      hi_seq = '{31, 29, 28, 27};
      hi_exp = '{1, 1, 1, 0};
      lo_seq = '{9, 12, 13};
      lo_exp = '{1, 1, 0};

      Reset = 1'b0; enable = 1'b0; period = 8'd3;
      hi_thresh = 8'd30; lo_thresh = 8'd10; clr_err = 1'b0;
      bus.Done = 1'b0; bus.rspData = 8'h00;

      // Reset values
      tick(); tick();
      chk("rst_req", 32'(bus.request), 32'(NOOP));
      chk("rst_reqdata", 32'(bus.reqData), 32'd0);
      chk("rst_sample", 32'(sample), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_max", 32'(temp_max), 32'h00);
      chk("rst_min", 32'(temp_min), 32'hFF);
      chk("rst_ahi", 32'(alarm_hi), 32'd0);
      chk("rst_alo", 32'(alarm_lo), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);

      // First poll 4 cycles after release with period 3, then capture 25
      enable = 1'b1;
      Reset  = 1'b1;
      do_poll(8'd25, 0, 1'b1);
      chk("reqdata_zero", 32'(bus.reqData), 32'd0);
      tick();
      chk("valid_one_pulse", 32'(sample_valid), 32'd0);

      // Hysteresis on the high alarm
      for (int i = 0; i < 4; i++) begin
         do_poll(8'(hi_seq[i]), 1, 1'b0);
         chk("hyst_hi_table", 32'(alarm_hi), 32'(hi_exp[i]));
      end
      // Hysteresis on the low alarm
      for (int i = 0; i < 3; i++) begin
         do_poll(8'(lo_seq[i]), 2, 1'b1);
         chk("hyst_lo_table", 32'(alarm_lo), 32'(lo_exp[i]));
      end

      // Saturating release levels near the rails
      hi_thresh = 8'd1; lo_thresh = 8'd254;
      do_poll(8'd2, 0, 1'b1);
      do_poll(8'd0, 1, 1'b1);
      do_poll(8'd255, 0, 1'b1);

      // Randomized polls, latencies, periods and thresholds
      for (int i = 0; i < 24; i++) begin
         period = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 3) == 0) begin
            hi_thresh = 8'($urandom_range(60, 250));
            lo_thresh = 8'($urandom_range(0, 80));
         end
         do_poll(8'($urandom_range(0, 255)), $urandom_range(0, 4), 1'b1);
      end

      // Timeout, Done outside BUSY ignored, sticky flag, clear vs set
      period = 8'd4;
      wait_req(0, 1'b0);
      run_timeout(1'b0);
      bus.Done = 1'b1; bus.rspData = 8'hEE;
      tick();
      bus.Done = 1'b0;
      chk("stray_done_sample", 32'(sample), 32'(m_sample));
      chk("stray_done_valid", 32'(sample_valid), 32'd0);
      chk("stray_done_max", 32'(temp_max), 32'(m_max));
      wait_req(0, 1'b0);
      run_timeout(1'b1);

      // Back to normal polling after a timeout
      do_poll(8'd77, 1, 1'b0);

      // Disable mid-transaction: completes, then no further requests
      wait_req(0, 1'b0);
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("dis_req_hold", 32'(bus.request), 32'(READ_TEMP));
         tick();
      end
      bus.Done = 1'b1; bus.rspData = 8'd40;
      model_capture(40);
      tick();
      bus.Done = 1'b0;
      check_capture("dis");
      reqs = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.request == READ_TEMP) reqs++;
      end
      chk("dis_no_more_req", 32'(reqs), 32'd0);

      // Period 0 behaves as 1
      period = 8'd0;
      enable = 1'b1;
      do_poll(8'd50, 1, 1'b1);
      do_poll(8'd51, 0, 1'b1);

      // Reset in BUSY drops request with no clock edge
      wait_req(2, 1'b1);
      #2;
      Reset = 1'b0;
      #1;
      chk("arst_req", 32'(bus.request), 32'(NOOP));
      chk("arst_sample", 32'(sample), 32'd0);
      chk("arst_max", 32'(temp_max), 32'h00);
      chk("arst_min", 32'(temp_min), 32'hFF);
      chk("arst_err", 32'(timeout_err), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
